gpio_in_debounce: RTL



---
 rtl/gpio_in_debounce.sv | 92 +++++++++
 1 files changed

// File: rtl/gpio_in_debounce.sv
// Pin conditioner: 2-flop synchroniser, prescaled debounce, rise/fall pulses.
// Sticky rising-edge flags are built only when GPIO_IN_EDGE_LATCH_EN is defined.
module gpio_in_debounce #(
  parameter int WIDTH      = 13,
  parameter int PRESCALE   = 1000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_async,
  input  logic [WIDTH-1:0] edge_clr,
  output logic [WIDTH-1:0] pin_level,
  output logic [WIDTH-1:0] pin_rise,
  output logic [WIDTH-1:0] pin_fall,
  output logic [WIDTH-1:0] edge_flag
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic [WIDTH-1:0] sync1, sync2;
  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [CW-1:0]    stab_cnt   [WIDTH];
  logic [CW-1:0]    stab_cnt_d [WIDTH];
  logic [WIDTH-1:0] level_d, rise_d, fall_d;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      pre_cnt <= '0;
    end else begin
      sync1   <= pin_async;
      sync2   <= sync1;
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
    end
  end

  // A disagreeing sample counts up; any agreeing sample restarts the run.
  always_comb begin
    level_d = pin_level;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      stab_cnt_d[i] = stab_cnt[i];
      if (tick) begin
        if (sync2[i] == pin_level[i]) begin
          stab_cnt_d[i] = '0;
        end else if (stab_cnt[i] == CNT_LAST) begin
          level_d[i]    = sync2[i];
          rise_d[i]     = sync2[i];
          fall_d[i]     = ~sync2[i];
          stab_cnt_d[i] = '0;
        end else begin
          stab_cnt_d[i] = stab_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_level <= '0;
      pin_rise  <= '0;
      pin_fall  <= '0;
      for (int i = 0; i < WIDTH; i++) stab_cnt[i] <= '0;
    end else begin
      pin_level <= level_d;
      pin_rise  <= rise_d;
      pin_fall  <= fall_d;
      for (int i = 0; i < WIDTH; i++) stab_cnt[i] <= stab_cnt_d[i];
    end
  end

`ifdef GPIO_IN_EDGE_LATCH_EN
  // Set takes priority over a same-cycle clear so no rise is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_flag <= '0;
    else        edge_flag <= (edge_flag & ~edge_clr) | rise_d;
  end
`else
  logic unused_edge_clr;
  assign unused_edge_clr = ^edge_clr;
  assign edge_flag       = '0;
`endif

endmodule
